// File: rtl/bid_arbiter.sv
// Four-requester sealed-bid arbiter: latches a snapshot of bids and balances, scans
// them in round-robin order, and grants the highest eligible bid for one cycle.
// Optional loss counters (starvation override) are built when ARB_STARVE_EN is defined.
module bid_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] bid_bus,
    input  logic [39:0] bal_bus,
    output logic [3:0]  grant,
    output logic        grant_valid,
    output logic [3:0]  win_bid,
    output logic        no_win,
    output logic        busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_COOL  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  rr_ptr;
    logic [1:0]  idx;
    logic [1:0]  cnt;
    logic [1:0]  best_idx;
    logic        found;
    logic [4:0]  best_key;
    logic [3:0]  req_s;
    logic [15:0] bid_s;
    logic [39:0] bal_s;
    logic [3:0]  elig_seen;

    logic [3:0]  cur_bid;
    logic [9:0]  cur_bal;
    logic        cur_sat;
    logic        cur_elig;
    logic [4:0]  cur_key;
    logic        better;
    logic        found_next;
    logic [1:0]  fin_idx;
    logic [3:0]  elig_next;

`ifdef ARB_STARVE_EN
    logic [2:0] loss [4];
`endif

    always_comb begin
        cur_bid = 4'd0;
        cur_bal = 10'd0;
        case (idx)
            2'd0: begin cur_bid = bid_s[3:0];   cur_bal = bal_s[9:0];   end
            2'd1: begin cur_bid = bid_s[7:4];   cur_bal = bal_s[19:10]; end
            2'd2: begin cur_bid = bid_s[11:8];  cur_bal = bal_s[29:20]; end
            default: begin cur_bid = bid_s[15:12]; cur_bal = bal_s[39:30]; end
        endcase
`ifdef ARB_STARVE_EN
        cur_sat = (loss[idx] == 3'd7);
`else
        cur_sat = 1'b0;
`endif
        // Strict less-than keeps the post-deduction balance at 1 or more.
        cur_elig   = req_s[idx] && (cur_bid != 4'd0) && ({6'd0, cur_bid} < cur_bal);
        // Saturated requesters sort above any plain bid via the key's top bit.
        cur_key    = {cur_sat, cur_bid};
        better     = cur_elig && (!found || (cur_key > best_key));
        found_next = found || better;
        fin_idx    = better ? idx : best_idx;
        elig_next  = elig_seen | (cur_elig ? (4'b0001 << idx) : 4'b0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= 2'd0;
            idx         <= 2'd0;
            cnt         <= 2'd0;
            best_idx    <= 2'd0;
            found       <= 1'b0;
            best_key    <= 5'd0;
            req_s       <= 4'd0;
            bid_s       <= 16'd0;
            bal_s       <= 40'd0;
            elig_seen   <= 4'd0;
            grant       <= 4'd0;
            grant_valid <= 1'b0;
            win_bid     <= 4'd0;
            no_win      <= 1'b0;
            busy        <= 1'b0;
`ifdef ARB_STARVE_EN
            for (int i = 0; i < 4; i++) loss[i] <= 3'd0;
`endif
        end else begin
            no_win <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        req_s     <= req;
                        bid_s     <= bid_bus;
                        bal_s     <= bal_bus;
                        idx       <= rr_ptr;
                        cnt       <= 2'd0;
                        found     <= 1'b0;
                        best_key  <= 5'd0;
                        best_idx  <= 2'd0;
                        elig_seen <= 4'd0;
                        busy      <= 1'b1;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    idx       <= idx + 2'd1;
                    cnt       <= cnt + 2'd1;
                    elig_seen <= elig_next;
                    if (better) begin
                        found    <= 1'b1;
                        best_key <= cur_key;
                        best_idx <= idx;
                    end
                    if (cnt == 2'd3) begin
                        if (found_next) begin
                            state <= S_GRANT;
                        end else begin
                            state  <= S_IDLE;
                            busy   <= 1'b0;
                            no_win <= 1'b1;
                        end
`ifdef ARB_STARVE_EN
                        for (int i = 0; i < 4; i++) begin
                            if (found_next && (2'(i) == fin_idx))
                                loss[i] <= 3'd0;
                            else if (elig_next[i] && (loss[i] != 3'd7))
                                loss[i] <= loss[i] + 3'd1;
                        end
`endif
                    end
                end
                S_GRANT: begin
                    grant       <= 4'b0001 << best_idx;
                    grant_valid <= 1'b1;
                    win_bid     <= best_key[3:0];
                    rr_ptr      <= best_idx + 2'd1;
                    state       <= S_COOL;
                end
                default: begin
                    grant       <= 4'd0;
                    grant_valid <= 1'b0;
                    win_bid     <= 4'd0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

`ifndef ARB_STARVE_EN
    logic unused_fin;
    assign unused_fin = ^fin_idx;
`endif
endmodule

// File: tb/tb_bid_arbiter.sv
// Self-checking bench for bid_arbiter: directed and random rounds scored against a
// round-level reference model through an expected-output queue.
module tb_bid_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] bid_bus;
    logic [39:0] bal_bus;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [3:0]  win_bid;
    logic        no_win;
    logic        busy;

    bid_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .bid_bus(bid_bus), .bal_bus(bal_bus),
        .grant(grant), .grant_valid(grant_valid), .win_bid(win_bid),
        .no_win(no_win), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    // entry: {cycle[15:0], no_win, grant[3:0], win_bid[3:0]}
    logic [24:0] exp_q[$];

    int m_rr = 0;
    int m_loss[4] = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-level model: best key over all eligible, ties to nearest from rr pointer.
    task automatic model(input logic [3:0] r, input logic [15:0] b, input logic [39:0] l,
                         output int w, output int wbid);
        int bid[4];
        int bal[4];
        int key[4];
        bit el[4];
        int maxk;
        int bestd;
        maxk = -1;
        for (int i = 0; i < 4; i++) begin
            bid[i] = int'(b[4*i +: 4]);
            bal[i] = int'(l[10*i +: 10]);
            el[i]  = r[i] && (bid[i] > 0) && (bid[i] < bal[i]);
            key[i] = bid[i];
`ifdef ARB_STARVE_EN
            if (m_loss[i] == 7) key[i] = key[i] + 100;
`endif
            if (el[i] && key[i] > maxk) maxk = key[i];
        end
        w = -1;
        wbid = 0;
        bestd = 99;
        for (int i = 0; i < 4; i++) begin
            if (el[i] && key[i] == maxk && ((i - m_rr + 4) % 4) < bestd) begin
                bestd = (i - m_rr + 4) % 4;
                w = i;
                wbid = bid[i];
            end
        end
        if (w >= 0) begin
`ifdef ARB_STARVE_EN
            for (int i = 0; i < 4; i++) begin
                if (i == w) m_loss[i] = 0;
                else if (el[i] && m_loss[i] < 7) m_loss[i] = m_loss[i] + 1;
            end
`endif
            m_rr = (w + 1) % 4;
        end
    endtask

    task automatic run_round(input logic [3:0] r, input logic [15:0] b, input logic [39:0] l,
                             input bit abort);
        int e0;
        int w;
        int wbid;
        logic [15:0] ecyc;
        @(negedge clk);
        req = r;
        bid_bus = b;
        bal_bus = l;
        @(posedge clk);
        #1;
        e0 = cyc;
        check("busy_after_e0", busy, 1);
        if (!abort) begin
            model(r, b, l, w, wbid);
            if (w < 0) begin
                ecyc = 16'(e0 + 4);
                exp_q.push_back({ecyc, 1'b1, 4'b0000, 4'b0000});
            end else begin
                ecyc = 16'(e0 + 5);
                exp_q.push_back({ecyc, 1'b0, 4'(4'b0001 << w), 4'(wbid)});
            end
        end
        // Scramble inputs mid-scan; the round must use the snapshot taken at E0.
        req = 4'($urandom);
        bid_bus = 16'($urandom);
        bal_bus = {8'($urandom), 32'($urandom)};
        repeat (2) @(posedge clk);
        #1;
        req = 4'd0;
        if (abort) begin
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("abort_grant", grant, 0);
            check("abort_grant_valid", grant_valid, 0);
            check("abort_busy", busy, 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            m_rr = 0;
            for (int i = 0; i < 4; i++) m_loss[i] = 0;
        end else begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!busy) break;
            end
            check("busy_clear_cycle", cyc, (w < 0) ? e0 + 4 : e0 + 6);
        end
    endtask

    // Monitor: pops one expectation per output event, checks idle outputs otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (grant_valid || no_win) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {grant_valid, no_win, grant}, 0);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check("out_cycle", 32'(cyc[15:0]), 32'(e[24:9]));
                    check("no_win", no_win, e[8]);
                    check("grant_valid", grant_valid, !e[8]);
                    check("grant", grant, e[7:4]);
                    check("win_bid", win_bid, e[3:0]);
                end
            end else begin
                check("grant_zero_when_invalid", grant, 0);
                check("win_bid_zero_when_invalid", win_bid, 0);
            end
        end
    end

    function automatic logic [15:0] pack_bid(input int b0, input int b1, input int b2, input int b3);
        return {4'(b3), 4'(b2), 4'(b1), 4'(b0)};
    endfunction

    function automatic logic [39:0] pack_bal(input int a0, input int a1, input int a2, input int a3);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req = 4'd0;
        bid_bus = 16'd0;
        bal_bus = 40'd0;
        repeat (3) @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_grant_valid", grant_valid, 0);
        check("reset_win_bid", win_bid, 0);
        check("reset_no_win", no_win, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // Higher bid wins; rr pointer moves to 2.
        run_round(4'b0011, pack_bid(5, 9, 0, 0), pack_bal(750, 750, 0, 0), 1'b0);
        // All-equal ties follow the round-robin pointer.
        run_round(4'b1111, pack_bid(7, 7, 7, 7), pack_bal(100, 100, 100, 100), 1'b0);
        run_round(4'b1111, pack_bid(7, 7, 7, 7), pack_bal(100, 100, 100, 100), 1'b0);
        // Bid equal to balance, and zero bid: both ineligible.
        run_round(4'b0001, pack_bid(6, 0, 0, 0), pack_bal(6, 0, 0, 0), 1'b0);
        run_round(4'b0001, pack_bid(0, 0, 0, 0), pack_bal(100, 0, 0, 0), 1'b0);
        // Bid one below balance is eligible.
        run_round(4'b0001, pack_bid(6, 0, 0, 0), pack_bal(7, 0, 0, 0), 1'b0);
        // Reset mid-scan, then the next round starts from pointer 0.
        run_round(4'b1111, pack_bid(7, 7, 7, 7), pack_bal(100, 100, 100, 100), 1'b1);
        run_round(4'b1111, pack_bid(7, 7, 7, 7), pack_bal(100, 100, 100, 100), 1'b0);

        // Repeated loser: requester 0 is forced through once its losses saturate.
        for (int n = 0; n < 9; n++)
            run_round(4'b0011, pack_bid(2, 9, 0, 0), pack_bal(500, 500, 0, 0), 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] b;
            logic [39:0] l;
            for (int i = 0; i < 4; i++) begin
                b[4*i +: 4]  = 4'($urandom_range(0, 15));
                l[10*i +: 10] = 10'($urandom_range(0, 20));
            end
            run_round(4'($urandom_range(1, 15)), b, l, 1'b0);
        end

        // Idle with no requests: nothing may change.
        req = 4'd0;
        repeat (8) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bid_arbiter.md
BID_ARBITER -- requirements
Module: bid_arbiter

Interface
REQ-001 The block SHALL have input `clk`, 1 bit: system clock; all state changes on the rising edge.
REQ-002 The block SHALL have input `rst`, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have input `req`, 4 bits: per-requester bid request, index 0..3.
REQ-004 The block SHALL have input `bid_bus`, 16 bits: requester i bid on bits [4i+3:4i], unsigned.
REQ-005 The block SHALL have input `bal_bus`, 40 bits: requester i bank balance on bits [10i+9:10i], unsigned.
REQ-006 The block SHALL have output `grant`, 4 bits: one-hot winner, driven to each requester's bank `granted`.
REQ-007 The block SHALL have output `grant_valid`, 1 bit: high in the same cycle as `grant`.
REQ-008 The block SHALL have output `win_bid`, 4 bits: winning bid value, valid while `grant_valid` is high.
REQ-009 The block SHALL have output `no_win`, 1 bit: one-cycle pulse when a round ends with no eligible bidder.
REQ-010 The block SHALL have output `busy`, 1 bit: high in every state except IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, SCAN, GRANT and COOL; all outputs SHALL be registered.
REQ-012 IDLE, edge E0 with |req=1:
- latch `req`, `bid_bus` and `bal_bus` into shadow registers;
- set scan index = rr_ptr; clear best-found;
- go to SCAN.
Input changes after E0 SHALL be ignored until the next IDLE.
REQ-013 Requester i SHALL be eligible only if all of the following hold:
- req[i]=1;
- bid != 0;
- bid < balance (strict), so that a deduction never leaves the balance below 1.
REQ-014 SCAN SHALL evaluate one index per edge (E1..E4) in the order rr_ptr, rr_ptr+1, ... mod 4.
- A candidate SHALL replace the best only if it is eligible and its bid is strictly greater than the best bid.
- Ties SHALL therefore go to the earlier index in round-robin order.
REQ-015 At E4 the FSM SHALL go to GRANT if a best exists; otherwise it SHALL go to IDLE, and `no_win` SHALL be high for the cycle following E4.
REQ-016 GRANT, edge E5: `grant`, `grant_valid` and `win_bid` SHALL be set; rr_ptr SHALL become (winner+1) mod 4; the FSM SHALL go to COOL.
REQ-017 COOL, edge E6: `grant`, `grant_valid` and `win_bid` SHALL clear, and the FSM SHALL go to IDLE.
- This gives exactly one high cycle of `grant`, spanning one falling edge for the bank's deduction.
- The earliest next latch SHALL be E7.
REQ-018 `grant` SHALL never have more than one bit set, and SHALL be zero whenever `grant_valid`=0.
REQ-019 Bid/balance comparison SHALL zero-extend the 4-bit bid to 10 bits.
REQ-020 When req=0 in IDLE, the FSM SHALL stay in IDLE with no output change.

Reset
REQ-021 With rst high, the block SHALL set:
- state = IDLE, rr_ptr = 0;
- grant = 0, grant_valid = 0, win_bid = 0, no_win = 0, busy = 0;
- shadow registers = 0, and starvation counters (if present) = 0.
REQ-022 Reset asserted mid-round (SCAN/GRANT/COOL) SHALL abort the round with no grant issued; any grant already asserted SHALL drop immediately (asynchronously).

Configuration
REQ-023 With macro `ARB_STARVE_EN` defined, each requester SHALL have a 3-bit loss counter.
- Increment (saturating at 7) when the requester was eligible in a round but did not win.
- Clear when the requester wins.
- Any eligible requester whose counter is 7 SHALL beat every non-saturated requester regardless of bid.
- Among saturated requesters, the REQ-014 rules SHALL apply.
REQ-024 Without `ARB_STARVE_EN`, the block SHALL have no loss counters and selection SHALL be pure highest-bid per REQ-014.

Verification
REQ-025 Reset then req=4'b0011, bids 5/9, balances 750/750, E0 at cycle 0 -> grant=4'b0010 and win_bid=9 high only in cycle 5, rr_ptr=2.
REQ-026 req=4'b1111, all bids 7, balances 100, rr_ptr=2 -> grant=4'b0100; next identical round -> grant=4'b1000.
REQ-027 req=4'b0001, bid=6, balance=6 (and a separate round with bid=0) -> no grant, no_win pulses 1 cycle after E4, busy clears.
REQ-028 rst asserted during SCAN cycle 3 -> grant stays 0, busy=0 at once; next round starts from rr_ptr=0.
REQ-029 The bench SHALL change bid_bus and bal_bus during SCAN and check that the winner reflects the values latched at E0.
REQ-030 With `ARB_STARVE_EN` defined: requester 0 (bid 2) loses 7 rounds to requester 1 (bid 9) -> round 8 grants 4'b0001 and requester 0's counter clears.
